// File: rtl/sw_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sw_pkg : shared types and limits for the Smith-Waterman job path    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sw_pkg;

  localparam int SCORE_BITWIDTH  = 10;
  localparam int REF_MAX_LENGTH  = 128;
  localparam int READ_MAX_LENGTH = 128;
  localparam int SEQ_W           = 256;
  localparam int LEN_W           = 8;
  localparam int POS_W           = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [SEQ_W-1:0] ref_seq;
    logic [SEQ_W-1:0] read_seq;
    logic [LEN_W-1:0] ref_len;
    logic [LEN_W-1:0] read_len;
  } job_t;

  typedef struct packed {
    logic [SCORE_BITWIDTH-1:0] score;
    logic [POS_W-1:0]          row;
    logic [POS_W-1:0]          col;
    logic                      err;
  } result_t;

  // A length is usable by the core only when it is 1..max_len bases.
  function automatic logic len_ok(input logic [LEN_W-1:0] len, input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sw_rr_arbiter : combinational 2-way round-robin grant               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sw_rr_arbiter
  import sw_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req_valid;
    grant_id    = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sw_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sw_job_arbiter : shares one SW core between two job requesters      |
// | Optional BUSY watchdog enabled by macro SW_ARB_TIMEOUT_EN           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sw_job_arbiter
  import sw_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SCORE_W        = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][SEQ_W-1:0] req_ref,
  input  logic [1:0][SEQ_W-1:0] req_read,
  input  logic [1:0][LEN_W-1:0] req_ref_len,
  input  logic [1:0][LEN_W-1:0] req_read_len,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [SCORE_W-1:0]    rsp_score,
  output logic [POS_W-1:0]      rsp_row,
  output logic [POS_W-1:0]      rsp_col,
  output logic                  rsp_err,
  output logic                  core_valid,
  input  logic                  core_ready,
  output logic [SEQ_W-1:0]      core_ref,
  output logic [SEQ_W-1:0]      core_read,
  output logic [LEN_W-1:0]      core_ref_len,
  output logic [LEN_W-1:0]      core_read_len,
  input  logic                  core_o_valid,
  output logic                  core_i_ready,
  input  logic [SCORE_W-1:0]    core_score,
  input  logic [POS_W-1:0]      core_row,
  input  logic [POS_W-1:0]      core_col,
  output logic                  core_abort,
  output logic                  busy,
  output logic                  grant_id
);

  state_t               r_state;
  state_t               w_state_nxt;
  job_t                 r_job;
  logic                 r_grant_id;
  logic                 r_last_grant;
  logic [SCORE_W-1:0]   r_score;
  logic [POS_W-1:0]     r_row;
  logic [POS_W-1:0]     r_col;
  logic                 r_err;

  logic                 w_arb_valid;
  logic                 w_arb_id;
  logic                 w_accept;
  logic                 w_len_ok;
  logic                 w_core_done;
  logic                 w_rsp_done;
  logic                 w_timeout;

  sw_rr_arbiter u_arb (
    .req_valid   (req_valid),
    .last_grant  (r_last_grant),
    .grant_valid (w_arb_valid),
    .grant_id    (w_arb_id)
  );

  // req_ready is gated by rst_n so no ready is offered while reset is held.
  assign w_accept    = (r_state == ST_IDLE) && w_arb_valid && rst_n;
  assign req_ready   = {w_arb_id, ~w_arb_id} & {2{w_accept}};
  assign w_len_ok    = len_ok(req_ref_len[w_arb_id], REF_MAX_LENGTH) &&
                       len_ok(req_read_len[w_arb_id], READ_MAX_LENGTH);
  assign w_core_done = (r_state == ST_BUSY) && core_o_valid;
  assign w_rsp_done  = (r_state == ST_RESP) && rsp_ready[r_grant_id];

`ifdef SW_ARB_TIMEOUT_EN
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_busy_cnt;

  // Counter reads k-1 in the k-th BUSY cycle, so the abort lands on cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt <= '0;
    end else if (r_state != ST_BUSY) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == ST_BUSY) && !core_o_valid && (r_busy_cnt == c_timeout_last);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  assign core_abort = w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_len_ok ? ST_ISSUE : ST_RESP;
      ST_ISSUE: if (core_ready) w_state_nxt = ST_BUSY;
      ST_BUSY:  if (w_core_done || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Pointer resets to 1 so that requester 0 wins the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_job        <= '0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_score      <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant_id <= w_arb_id;
        r_job      <= '{ref_seq:  req_ref[w_arb_id],
                        read_seq: req_read[w_arb_id],
                        ref_len:  req_ref_len[w_arb_id],
                        read_len: req_read_len[w_arb_id]};
        if (!w_len_ok) begin
          r_score <= '0;
          r_row   <= '0;
          r_col   <= '0;
          r_err   <= 1'b1;
        end
      end
      if (w_core_done) begin
        r_score <= core_score;
        r_row   <= core_row;
        r_col   <= core_col;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_score <= '0;
        r_row   <= '0;
        r_col   <= '0;
        r_err   <= 1'b1;
      end
      if (w_rsp_done) begin
        r_last_grant <= r_grant_id;
      end
    end
  end

  assign core_valid    = (r_state == ST_ISSUE);
  assign core_ref      = r_job.ref_seq;
  assign core_read     = r_job.read_seq;
  assign core_ref_len  = r_job.ref_len;
  assign core_read_len = r_job.read_len;
  assign core_i_ready  = (r_state == ST_BUSY);
  assign busy          = (r_state != ST_IDLE);
  assign grant_id      = r_grant_id;
  assign rsp_valid     = {r_grant_id, ~r_grant_id} & {2{r_state == ST_RESP}};
  assign rsp_score     = r_score;
  assign rsp_row       = r_row;
  assign rsp_col       = r_col;
  assign rsp_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sw_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sw_job_arbiter : directed job table plus corner-case sequences   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sw_job_arbiter;

`ifdef SW_ARB_TIMEOUT_EN
  localparam int LONG_LAT = 40;
`else
  localparam int LONG_LAT = 300;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][255:0] req_ref;
  logic [1:0][255:0] req_read;
  logic [1:0][7:0]   req_ref_len;
  logic [1:0][7:0]   req_read_len;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [9:0]        rsp_score;
  logic [6:0]        rsp_row;
  logic [6:0]        rsp_col;
  logic              rsp_err;
  logic              core_valid;
  logic              core_ready;
  logic [255:0]      core_ref;
  logic [255:0]      core_read;
  logic [7:0]        core_ref_len;
  logic [7:0]        core_read_len;
  logic              core_o_valid;
  logic              core_i_ready;
  logic [9:0]        core_score;
  logic [6:0]        core_row;
  logic [6:0]        core_col;
  logic              core_abort;
  logic              busy;
  logic              grant_id;

  int checks = 0;
  int errors = 0;

  sw_job_arbiter #(
    .TIMEOUT_CYCLES (50),
    .SCORE_W        (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_ref       (req_ref),
    .req_read      (req_read),
    .req_ref_len   (req_ref_len),
    .req_read_len  (req_read_len),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_score     (rsp_score),
    .rsp_row       (rsp_row),
    .rsp_col       (rsp_col),
    .rsp_err       (rsp_err),
    .core_valid    (core_valid),
    .core_ready    (core_ready),
    .core_ref      (core_ref),
    .core_read     (core_read),
    .core_ref_len  (core_ref_len),
    .core_read_len (core_read_len),
    .core_o_valid  (core_o_valid),
    .core_i_ready  (core_i_ready),
    .core_score    (core_score),
    .core_row      (core_row),
    .core_col      (core_col),
    .core_abort    (core_abort),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] ref_len;
    logic [7:0] read_len;
    int         lat;
    logic [9:0] c_score;
    logic [6:0] c_row;
    logic [6:0] c_col;
    logic [1:0] exp_rsp;
    logic       exp_err;
    logic [9:0] exp_score;
    logic [6:0] exp_row;
    logic [6:0] exp_col;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [255:0] pat(input int i, input int k);
    logic [31:0] w;
    w = 32'h1357_0000 ^ 32'(i * 32'h0101_0000) ^ 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ctl"}, {req_ready, rsp_valid, core_valid, core_i_ready, core_abort, busy, grant_id}, '0);
    chk({nm, "_data"}, {rsp_score, rsp_row, rsp_col, rsp_err, core_ref_len, core_read_len}, '0);
    chk({nm, "_seq"}, core_ref | core_read, '0);
  endtask

  task automatic run_job(input vec_t v, input int k);
    int g;
    g = v.exp_rsp[1] ? 1 : 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req_ref[i]      = pat(i, k);
      req_read[i]     = pat(i + 2, k);
      req_ref_len[i]  = v.ref_len;
      req_read_len[i] = v.read_len;
    end
    req_valid = v.req;
    #1;
    chk("req_ready", req_ready, v.exp_rsp);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("grant_id", grant_id, g);
    if (v.exp_err) begin
      chk("reject_core_valid", core_valid, 1'b0);
    end else begin
      chk("core_valid_lat", core_valid, 1'b1);
      chk("core_ref", core_ref, pat(g, k));
      chk("core_read", core_read, pat(g + 2, k));
      chk("core_lens", {core_ref_len, core_read_len}, {v.ref_len, v.read_len});
      core_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      core_ready = 1'b0;
      #1;
      chk("core_accept_once", core_valid, 1'b0);
      repeat (v.lat) @(negedge clk);
      core_o_valid = 1'b1;
      core_score   = v.c_score;
      core_row     = v.c_row;
      core_col     = v.c_col;
      #1;
      chk("core_i_ready", core_i_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      core_o_valid = 1'b0;
      core_score   = 10'h2aa;
      #1;
    end
    chk("rsp_valid", rsp_valid, v.exp_rsp);
    chk("rsp_bus", {rsp_score, rsp_row, rsp_col, rsp_err},
        {v.exp_score, v.exp_row, v.exp_col, v.exp_err});
    rsp_ready = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("rsp_done", {busy, rsp_valid}, 3'b000);
  endtask

  task automatic start_busy(input int g, input int k);
    @(negedge clk);
    req_ref[g]      = pat(g, k);
    req_read[g]     = pat(g + 2, k);
    req_ref_len[g]  = 8'd5;
    req_read_len[g] = 8'd5;
    req_valid       = (g == 1) ? 2'b10 : 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 2'b00;
    core_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_ready = 1'b0;
    #1;
    chk("busy_entry", {busy, core_i_ready}, 2'b11);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vboth;
    int   n;
    logic ok;

    vecs[0] = '{2'b11, 8'd10,  8'd20,  3,        10'd5,   7'd1,   7'd2,   2'b01, 1'b0, 10'd5,    7'd1,   7'd2};
    vecs[1] = '{2'b11, 8'd30,  8'd40,  1,        10'd6,   7'd11,  7'd12,  2'b10, 1'b0, 10'd6,    7'd11,  7'd12};
    vecs[2] = '{2'b11, 8'd64,  8'd64,  2,        10'd300, 7'd50,  7'd60,  2'b01, 1'b0, 10'd300,  7'd50,  7'd60};
    vecs[3] = '{2'b11, 8'd1,   8'd128, 0,        10'd512, 7'd0,   7'd127, 2'b10, 1'b0, 10'd512,  7'd0,   7'd127};
    vecs[4] = '{2'b01, 8'd128, 8'd128, LONG_LAT, 10'd37,  7'd100, 7'd90,  2'b01, 1'b0, 10'd37,   7'd100, 7'd90};
    vecs[5] = '{2'b10, 8'd50,  8'd0,   0,        10'd999, 7'd9,   7'd9,   2'b10, 1'b1, 10'd0,    7'd0,   7'd0};
    vecs[6] = '{2'b10, 8'd50,  8'd129, 0,        10'd999, 7'd9,   7'd9,   2'b10, 1'b1, 10'd0,    7'd0,   7'd0};
    vecs[7] = '{2'b01, 8'd1,   8'd1,   0,        10'd1023,7'd127, 7'd127, 2'b01, 1'b0, 10'd1023, 7'd127, 7'd127};
    vecs[8] = '{2'b10, 8'd0,   8'd5,   0,        10'd999, 7'd9,   7'd9,   2'b10, 1'b1, 10'd0,    7'd0,   7'd0};
    vecs[9] = '{2'b11, 8'd128, 8'd127, 4,        10'd42,  7'd64,  7'd32,  2'b01, 1'b0, 10'd42,   7'd64,  7'd32};
    vboth   = '{2'b11, 8'd20,  8'd20,  2,        10'd88,  7'd8,   7'd9,   2'b01, 1'b0, 10'd88,   7'd8,   7'd9};

    rst_n        = 1'b0;
    req_valid    = '0;
    req_ref      = '0;
    req_read     = '0;
    req_ref_len  = '0;
    req_read_len = '0;
    rsp_ready    = '0;
    core_ready   = 1'b0;
    core_o_valid = 1'b0;
    core_score   = '0;
    core_row     = '0;
    core_col     = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i], i);
    end

    // Rejected job with rsp_ready already high: one RESP cycle only.
    @(negedge clk);
    req_ref_len[1]  = 8'd0;
    req_read_len[1] = 8'd7;
    req_valid       = 2'b10;
    rsp_ready       = 2'b10;
    #1;
    chk("h0_ready", req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("h0_rsp", {rsp_valid, rsp_err, core_valid}, {2'b10, 1'b1, 1'b0});
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("h0_done", {busy, rsp_valid}, 3'b000);

    // Core back-pressure in ISSUE, then response back-pressure with stray inputs.
    @(negedge clk);
    req_ref[0]      = pat(0, 20);
    req_read[0]     = pat(2, 20);
    req_ref_len[0]  = 8'd64;
    req_read_len[0] = 8'd64;
    req_valid       = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid      = 2'b00;
    req_ref[0]     = '1;
    req_ref_len[0] = 8'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("h1_issue_ctl", {core_valid, core_ref_len}, {1'b1, 8'd64});
      chk("h1_issue_ref", core_ref, pat(0, 20));
      @(negedge clk);
    end
    core_ready = 1'b1;
    #1;
    chk("h1_issue_last", core_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    core_ready = 1'b0;
    #1;
    chk("h1_single_accept", {core_valid, core_i_ready}, 2'b01);
    core_o_valid = 1'b1;
    core_score   = 10'd77;
    core_row     = 7'd3;
    core_col     = 7'd4;
    @(posedge clk);
    @(negedge clk);
    core_score = 10'h155;
    core_row   = 7'h55;
    core_col   = 7'h2a;
    rsp_ready  = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("h1_rsp_hold", {rsp_valid, rsp_score, rsp_row, rsp_col, rsp_err},
          {2'b01, 10'd77, 7'd3, 7'd4, 1'b0});
      @(negedge clk);
    end
    core_o_valid = 1'b0;
    rsp_ready    = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("h1_done", {busy, rsp_valid}, 3'b000);

    // Silent core: watchdog abort when enabled, otherwise BUSY persists.
    start_busy(1, 30);
`ifdef SW_ARB_TIMEOUT_EN
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      if (core_abort) begin
        n = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("abort_cycle", n, 50);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort_pulse_end", core_abort, 1'b0);
    chk("abort_rsp", {rsp_valid, rsp_score, rsp_row, rsp_col, rsp_err},
        {2'b10, 10'd0, 7'd0, 7'd0, 1'b1});
    rsp_ready = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    start_busy(0, 31);
    repeat (5) @(negedge clk);
`else
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (!busy || core_abort || rsp_valid != 2'b00) ok = 1'b0;
    end
    chk("busy_hold", ok, 1'b1);
`endif

    // Reset while BUSY discards the job; pointer favours requester 0 afterwards.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("post_reset");
    run_job(vboth, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
